// File: rtl/datapath_controller_pkg.sv
// Shared constants for the datapath controller: opcodes, FSM states,
// ALU operand-2 source encodings and ALU operation codes.
package datapath_controller_pkg;

    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_SLL  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;
    localparam logic [3:0] OP_LW   = 4'd11;
    localparam logic [3:0] OP_SW   = 4'd12;
    localparam logic [3:0] OP_J    = 4'd13;
    localparam logic [3:0] OP_NOP  = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [1:0] SRC_REG   = 2'd0;
    localparam logic [1:0] SRC_IMM   = 2'd1;
    localparam logic [1:0] SRC_SHAMT = 2'd2;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SLL = 4'd8;
    localparam logic [3:0] ALU_SRL = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: maps the 16-bit IR to ALU controls,
// register/immediate fields and the (ungated) write controls.
module instr_decoder
    import datapath_controller_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  alu_sel,
    output logic [1:0]  alu_src,
    output logic [2:0]  dst,
    output logic [2:0]  src1,
    output logic [2:0]  src2,
    output logic [2:0]  shamt,
    output logic [5:0]  iconst,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        mem_write,
    output logic        is_jump,
    output logic        is_halt
);
    logic [3:0] opcode;

    assign opcode = ir[15:12];
    assign dst    = ir[11:9];
    assign src1   = ir[8:6];
    assign src2   = ir[5:3];
    assign shamt  = ir[2:0];
    assign iconst = ir[5:0];

    always_comb begin
        alu_sel    = ALU_ADD;
        alu_src    = SRC_REG;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        is_jump    = 1'b0;
        is_halt    = 1'b0;
        case (opcode)
            OP_ADDI: begin
                alu_src   = SRC_IMM;
                reg_write = 1'b1;
            end
            OP_SLL: begin
                alu_sel   = ALU_SLL;
                alu_src   = SRC_SHAMT;
                reg_write = 1'b1;
            end
            OP_SRL: begin
                alu_sel   = ALU_SRL;
                alu_src   = SRC_SHAMT;
                reg_write = 1'b1;
            end
            OP_LW: begin
                alu_src    = SRC_IMM;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            OP_SW: begin
                alu_src   = SRC_IMM;
                mem_write = 1'b1;
            end
            OP_J:    is_jump = 1'b1;
            OP_NOP:  ;
            OP_HALT: is_halt = 1'b1;
            // opcodes 0-7: register ALU ops, ALU code is the opcode itself
            default: begin
                alu_sel   = opcode;
                reg_write = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle fetch/decode/execute controller: owns the FSM, pc, IR and the
// retired-instruction counter; decoding is delegated to instr_decoder.
module datapath_controller
    import datapath_controller_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    input  logic            imem_ack,
    output logic [3:0]      ALUselect,
    output logic [2:0]      dst,
    output logic [2:0]      src1,
    output logic [2:0]      src2,
    output logic [2:0]      shamt,
    output logic [5:0]      iconst,
    output logic [1:0]      ALUsrc,
    output logic            regWrite,
    output logic            memtoReg,
    output logic            memWrite,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            illegal,
    output logic [15:0]     retired
);
    localparam logic [PC_W-1:0] PC0 = PC_W'(RESET_PC);

    state_t      state;
    logic [15:0] ir;

    logic [3:0] d_alu_sel;
    logic [1:0] d_alu_src;
    logic [2:0] d_dst, d_src1, d_src2, d_shamt;
    logic [5:0] d_iconst;
    logic       d_reg_write, d_mem_to_reg, d_mem_write, d_is_jump, d_is_halt;

    instr_decoder u_dec (
        .ir         (ir),
        .alu_sel    (d_alu_sel),
        .alu_src    (d_alu_src),
        .dst        (d_dst),
        .src1       (d_src1),
        .src2       (d_src2),
        .shamt      (d_shamt),
        .iconst     (d_iconst),
        .reg_write  (d_reg_write),
        .mem_to_reg (d_mem_to_reg),
        .mem_write  (d_mem_write),
        .is_jump    (d_is_jump),
        .is_halt    (d_is_halt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            pc      <= PC0;
            ir      <= 16'h0000;
            retired <= 16'h0000;
            illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        state   <= ST_FETCH;
                        pc      <= PC0;
                        retired <= 16'h0000;
                        illegal <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_data;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: state <= ST_EXEC;
                ST_EXEC: begin
                    if (retired != 16'hFFFF)
                        retired <= retired + 16'd1;
                    if (d_is_halt) begin
                        state <= ST_HALTED;
                    end else begin
                        state <= ST_FETCH;
                        pc    <= d_is_jump ? PC_W'(ir) : pc + PC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic show_fields, in_exec;

    assign in_exec     = (state == ST_EXEC);
    assign show_fields = (state == ST_DECODE) || in_exec;

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign busy      = (state == ST_FETCH) || show_fields;
    assign halted    = (state == ST_HALTED);

    // Fields are visible only while the instruction is live; writes pulse in EXEC only.
    assign ALUselect = show_fields ? d_alu_sel : 4'd0;
    assign ALUsrc    = show_fields ? d_alu_src : 2'd0;
    assign dst       = show_fields ? d_dst     : 3'd0;
    assign src1      = show_fields ? d_src1    : 3'd0;
    assign src2      = show_fields ? d_src2    : 3'd0;
    assign shamt     = show_fields ? d_shamt   : 3'd0;
    assign iconst    = show_fields ? d_iconst  : 6'd0;
    assign regWrite  = in_exec & d_reg_write;
    assign memtoReg  = in_exec & d_mem_to_reg;
    assign memWrite  = in_exec & d_mem_write;

endmodule

// File: tb/tb_datapath_controller.sv
// Randomized self-checking bench for datapath_controller against an
// instruction-level reference model (pc, retired count, expected controls).
module tb_datapath_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_ack = 1'b0;
    logic [3:0]  ALUselect;
    logic [2:0]  dst, src1, src2, shamt;
    logic [5:0]  iconst;
    logic [1:0]  ALUsrc;
    logic        regWrite, memtoReg, memWrite;
    logic [7:0]  pc;
    logic        busy, halted, illegal;
    logic [15:0] retired;

    datapath_controller #(.PC_W(8), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ack(imem_ack),
        .ALUselect(ALUselect), .dst(dst), .src1(src1), .src2(src2), .shamt(shamt),
        .iconst(iconst), .ALUsrc(ALUsrc), .regWrite(regWrite), .memtoReg(memtoReg),
        .memWrite(memWrite), .pc(pc), .busy(busy), .halted(halted), .illegal(illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0] mpc;
    int         mret;

    // Expected {ALUselect, ALUsrc, regWrite, memtoReg, memWrite} from the opcode table
    function automatic logic [8:0] exp_ctl(input logic [3:0] op);
        case (op)
            4'd8:    return {4'd0, 2'd1, 3'b100};
            4'd9:    return {4'd8, 2'd2, 3'b100};
            4'd10:   return {4'd9, 2'd2, 3'b100};
            4'd11:   return {4'd0, 2'd1, 3'b110};
            4'd12:   return {4'd0, 2'd1, 3'b001};
            4'd13, 4'd14, 4'd15: return {4'd0, 2'd0, 3'b000};
            default: return {op,   2'd0, 3'b100};
        endcase
    endfunction

    function automatic logic [17:0] exp_fields(input logic [15:0] ins);
        return {ins[11:9], ins[8:6], ins[5:3], ins[2:0], ins[5:0]};
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_halted"}, halted, 0);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_ret"}, retired, 0);
        chk({tag, "_outs"}, {ALUselect, ALUsrc, dst, src1, src2, shamt, iconst,
                             regWrite, memtoReg, memWrite, illegal}, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mpc  = 8'h00;
        mret = 0;
        chk("start_busy", busy, 1);
        chk("start_pc", pc, 0);
        chk("start_ret", retired, 0);
        chk("start_illegal", illegal, 0);
    endtask

    // One instruction: FETCH (dly wait cycles + ack cycle), DECODE, EXEC
    task automatic run_instr(input logic [15:0] ins, input int dly);
        logic [8:0] ec;
        ec = exp_ctl(ins[15:12]);
        chk("fetch_req", imem_req, 1);
        chk("fetch_addr", imem_addr, mpc);
        for (int i = 0; i < dly; i++) begin
            start     = 1'($urandom_range(0, 1));
            imem_ack  = 1'b0;
            imem_data = 16'($urandom);
            @(negedge clk);
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, mpc);
            chk("wait_wr", {regWrite, memtoReg, memWrite}, 0);
        end
        start     = 1'b0;
        imem_ack  = 1'b1;
        imem_data = ins;
        @(negedge clk);
        // DECODE: spurious ack and start must be ignored
        imem_ack  = 1'($urandom_range(0, 1));
        imem_data = 16'($urandom);
        start     = 1'($urandom_range(0, 1));
        chk("dec_req", imem_req, 0);
        chk("dec_busy", busy, 1);
        chk("dec_wr", {regWrite, memtoReg, memWrite}, 0);
        chk("dec_fields", {dst, src1, src2, shamt, iconst}, exp_fields(ins));
        @(negedge clk);
        imem_ack = 1'b0;
        start    = 1'b0;
        chk("exec_wr", {regWrite, memtoReg, memWrite}, ec[2:0]);
        chk("exec_fields", {dst, src1, src2, shamt, iconst}, exp_fields(ins));
        if (ins[15:12] <= 4'd12)
            chk("exec_alu", {ALUselect, ALUsrc}, ec[8:3]);
        chk("exec_pc", pc, mpc);
        @(negedge clk);
        if (ins[15:12] == 4'd13)      mpc = ins[7:0];
        else if (ins[15:12] != 4'd15) mpc = mpc + 8'd1;
        if (mret < 65535) mret++;
        chk("next_pc", pc, mpc);
        chk("next_ret", retired, 16'(mret));
        chk("next_wr", {regWrite, memtoReg, memWrite}, 0);
        chk("next_halted", halted, (ins[15:12] == 4'd15) ? 1 : 0);
        chk("next_busy", busy, (ins[15:12] == 4'd15) ? 0 : 1);
    endtask

    initial begin
        logic [15:0] r;
        mpc  = 8'h00;
        mret = 0;
        repeat (2) @(negedge clk);
        check_idle_zero("rst");
        reset = 1'b1;
        @(negedge clk);
        check_idle_zero("idle");

        do_start();
        run_instr(16'h8A45, 0);   // ADDI r5,r1,5
        run_instr(16'hB283, 3);   // LW
        run_instr(16'hC283, 1);   // SW
        run_instr(16'hD020, 0);   // J 0x20
        chk("jump_pc", pc, 8'h20);
        run_instr(16'hD0FF, 2);   // J 0xFF
        run_instr(16'hE000, 0);   // NOP wraps pc
        chk("wrap_pc", pc, 8'h00);

        for (int k = 0; k < 60; k++) begin
            r = 16'($urandom);
            if (r[15:12] == 4'd15) r[15:12] = 4'd14;
            run_instr(r, int'($urandom_range(0, 3)));
        end
        run_instr(16'hF000, 1);   // HALT
        repeat (2) @(negedge clk);
        chk("halt_stay", halted, 1);
        chk("halt_pc", pc, mpc);

        // Restart from HALTED, then reset while waiting in FETCH
        do_start();
        run_instr(16'h1234, 0);
        run_instr(16'h9A4B, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_idle_zero("midrst");
        @(negedge clk);
        imem_ack  = 1'b1;         // late ack must be ignored
        imem_data = 16'h8A45;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        check_idle_zero("late_ack");

        do_start();
        run_instr(16'h3F3F, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/datapath_controller.md
DATAPATH_CONTROLLER -- requirements
Module: datapath_controller

Interface
REQ-001 The block SHALL have parameter PC_W, default 8, giving the program counter width.
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the first fetch address.
REQ-003 The block SHALL run on one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 start  in  1  begin execution from IDLE or HALTED.
REQ-007 imem_req  out  1  fetch request.
REQ-008 imem_addr  out  PC_W  fetch address; equals pc.
REQ-009 imem_data  in  16  instruction; sampled in the imem_ack cycle.
REQ-010 imem_ack  in  1  fetch complete.
REQ-011 ALUselect  out  4  ALU operation.
REQ-012 dst, src1, src2, shamt  out  3 each  register and shift fields.
REQ-013 iconst  out  6  immediate field.
REQ-014 ALUsrc  out  2  ALU operand 2 source: 0 = register, 1 = iconst, 2 = shamt.
REQ-015 regWrite, memtoReg, memWrite  out  1 each  datapath write controls.
REQ-016 pc  out  PC_W  program counter.
REQ-017 busy, halted, illegal  out  1 each  status flags.
REQ-018 retired  out  16  count of retired instructions.

Function
REQ-019 The block SHALL have the states IDLE, FETCH, DECODE, EXEC and HALTED.
REQ-020 IDLE SHALL go to FETCH on start=1, loading pc with RESET_PC, clearing illegal and clearing retired.
REQ-021 FETCH SHALL hold imem_req=1 with imem_addr=pc stable until imem_ack=1, then latch imem_data into IR and go to DECODE.
REQ-022 imem_ack SHALL be ignored outside FETCH, and imem_req SHALL be 0 outside FETCH.
REQ-023 DECODE SHALL last one cycle, drive the field outputs from IR, and hold all write controls at 0.
REQ-024 EXEC SHALL last one cycle, assert the decoded regWrite/memWrite/memtoReg, update pc, increment retired, and then go to FETCH.
REQ-025 Each instruction SHALL take (cycles to ack) + 2 cycles, and write controls SHALL pulse for exactly one cycle per instruction.
REQ-026 IR field map: [15:12] opcode, [11:9] dst, [8:6] src1, [5:3] src2, [2:0] shamt, [5:0] iconst; field outputs SHALL be held from IR in DECODE and EXEC.
REQ-027 Opcodes 0-7 SHALL decode as register ALU ops: ALUselect=opcode, ALUsrc=0, regWrite=1.
REQ-028 Opcode 8 (ADDI) SHALL decode as ALUselect=0, ALUsrc=1, regWrite=1.
REQ-029 Opcodes 9 (SLL) and 10 (SRL) SHALL decode as ALUselect=8 and 9 respectively, ALUsrc=2, regWrite=1.
REQ-030 Opcode 11 (LW) SHALL decode as ALUselect=0, ALUsrc=1, memtoReg=1, regWrite=1.
REQ-031 Opcode 12 (SW) SHALL decode as ALUselect=0, ALUsrc=1, memWrite=1.
REQ-032 Opcode 13 (J) SHALL set pc to IR[PC_W-1:0] in EXEC with no writes.
REQ-033 Opcode 14 SHALL decode as NOP; opcode 15 (HALT) SHALL go from EXEC to HALTED without incrementing pc.
REQ-034 For all opcodes other than J and HALT, pc SHALL become pc+1 modulo 2^PC_W, wrapping from all-ones to 0.
REQ-035 retired SHALL saturate at 16'hFFFF; HALT SHALL count as retired.
REQ-036 The illegal flag is reserved for future opcodes, SHALL stay 0 in this revision, and SHALL clear only on start or reset.
REQ-037 busy SHALL be 1 in FETCH, DECODE and EXEC; halted SHALL be 1 only in HALTED.
REQ-038 In HALTED, start=1 SHALL restart exactly as from IDLE; start SHALL be ignored in FETCH, DECODE and EXEC.
REQ-039 Write controls (regWrite, memtoReg, memWrite) SHALL be 0 in every state except EXEC.

Reset
REQ-040 On reset=0 the block SHALL immediately enter IDLE, in any state including mid-fetch.
REQ-041 During reset, pc SHALL be RESET_PC, IR SHALL be 0, retired SHALL be 0, and all outputs and flags SHALL be 0.
REQ-042 A fetch aborted by reset SHALL not be retried, and a late imem_ack after reset SHALL be ignored.

Structure
REQ-043 A shared package SHALL hold the opcode constants, the state enum, the ALUsrc encodings (SRC_REG, SRC_IMM, SRC_SHAMT) and the ALUselect codes.
REQ-044 Decoding SHALL be a combinational sub-module instr_decoder that maps IR to the control outputs; the FSM, pc, IR and retired counter stay in datapath_controller.

Verification
REQ-045 Reset, start, ack after 0 cycles, IR=16'h8A45 (ADDI r5,r1,5) -> EXEC cycle has ALUsrc=1, iconst=5, dst=5, regWrite=1, pc 0->1.
REQ-046 Ack delayed 3 cycles -> imem_req held high with imem_addr constant for 4 cycles, and no write pulse before EXEC.
REQ-047 LW 16'hB283 then SW 16'hC283 -> memtoReg=1 and regWrite=1 for one cycle, then memWrite=1 and regWrite=0 for one cycle.
REQ-048 J to 8'h20, then pc=8'hFF with NOP -> pc=8'h20 after J; pc wraps from 8'hFF to 8'h00.
REQ-049 Spurious ack in DECODE, and start while busy -> no state change.
REQ-050 HALT 16'hF000 -> halted=1, busy=0, pc unchanged, retired+1; reset=0 asserted mid-FETCH -> IDLE and all outputs 0 immediately.
